// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg
//  Shared definitions for the interrupt controller:
//   - bus register address map (PENDING, MASK, VECTOR, EOI)
//   - controller FSM state encoding (IDLE, REQ, SERVICE)
//   - VECTOR register layout (valid bit position, source id width)
//   - make_vector() helper that packs {valid, zeros, id} into a bus word
package irq_ctrl_pkg;

  localparam int BUS_W         = 16;
  localparam int ID_W          = 4;
  localparam int VEC_VALID_BIT = 15;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_VECTOR  = 2'd2;
  localparam logic [1:0] ADDR_EOI     = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Builds the VECTOR read word: valid flag in the top bit, source id in the low nibble.
  function automatic logic [BUS_W-1:0] make_vector(input logic valid,
                                                   input logic [ID_W-1:0] id);
    logic [BUS_W-1:0] word;
    word                = '0;
    word[VEC_VALID_BIT] = valid;
    word[ID_W-1:0]      = id;
    return word;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc
//  Combinational fixed-priority encoder: index 0 has the highest priority.
//  Ports:
//   req  in   NUM_SRC  request vector (pending & mask)
//   any  out  1        at least one request bit is set
//   id   out  ID_W     index of the lowest set request bit (0 when none)
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    id
);

  // Scanning from the top down lets the lowest set index overwrite higher ones.
  always_comb begin
    any = |req;
    id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller
//  Gathers peripheral interrupt lines into a single prioritised request for the CPU.
//  The CPU acknowledges by reading VECTOR (which reports and claims the winning source)
//  and finishes service by writing EOI. Only one source is in service at a time.
//  Build option:
//   IRQ_EDGE_EN  defined   -> pending bits set on rising edges of src only
//                undefined -> pending bits set while src is high (level mode)
//  Ports:
//   clk      in   1        system clock, posedge
//   rst      in   1        synchronous active-high reset
//   read     in   1        bus read strobe
//   write    in   1        bus write strobe
//   addr     in   2        register select: 0 PENDING, 1 MASK, 2 VECTOR, 3 EOI
//   in_bus   in   16       write data
//   out_bus  out  16       registered read data, held until the next read
//   src      in   NUM_SRC  interrupt lines, active-high
//   irq      out  1        interrupt request to the CPU
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read,
  input  logic               write,
  input  logic [1:0]         addr,
  input  logic [BUS_W-1:0]   in_bus,
  output logic [BUS_W-1:0]   out_bus,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq
);

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [BUS_W-1:0]   out_bus_q, out_bus_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;

  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] active;
  logic               any_active;
  logic [ID_W-1:0]    winner;
  logic               ack;

  // Register bits above NUM_SRC have no storage behind them.
  logic               unused_in_bus;
  assign unused_in_bus = ^in_bus[BUS_W-1:NUM_SRC];

`ifdef IRQ_EDGE_EN
  logic [NUM_SRC-1:0] src_q, src_d;

  assign src_d   = src;
  // A line already high when reset releases counts as a new edge because src_q starts at 0.
  assign set_vec = src & ~src_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
    end else begin
      src_q <= src_d;
    end
  end
`else
  assign set_vec = src;
`endif

  assign active = pending_q & mask_q;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req (active),
    .any (any_active),
    .id  (winner)
  );

  // Acknowledge only counts when a winner exists; otherwise REQ is about to fall back to IDLE.
  assign ack = read && (addr == ADDR_VECTOR) && (state_q == REQ) && any_active;

  // Next-state logic: register updates, read data capture and the service FSM.
  // Pending clears (W1C and acknowledge) are applied before new sets so a source
  // asserting in the same cycle is never lost.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mask_d    = mask_q;
    out_bus_d = out_bus_q;
    cur_id_d  = cur_id_q;
    clr_vec   = '0;

    if (write && (addr == ADDR_PENDING)) begin
      clr_vec = in_bus[NUM_SRC-1:0];
    end
    if (ack) begin
      clr_vec  = clr_vec | (NUM_SRC'(1) << winner);
      cur_id_d = winner;
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;

    if (write && (addr == ADDR_MASK)) begin
      mask_d = in_bus[NUM_SRC-1:0];
    end

    if (read) begin
      case (addr)
        ADDR_PENDING: out_bus_d = BUS_W'(pending_q);
        ADDR_MASK:    out_bus_d = BUS_W'(mask_q);
        ADDR_VECTOR:  out_bus_d = ack ? make_vector(1'b1, winner)
                                      : make_vector(1'b0, cur_id_q);
        default:      out_bus_d = '0;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (any_active) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          state_d = SERVICE;
        end else if (!any_active) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (write && (addr == ADDR_EOI)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also abandons any source in service.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      out_bus_q <= '0;
      cur_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      out_bus_q <= out_bus_d;
      cur_id_q  <= cur_id_d;
    end
  end

  assign out_bus = out_bus_q;
  assign irq     = (state_q == REQ);

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
//  Directed scoreboard bench for irq_controller. Every check is a bus read: the
//  stimulus side queues the hand-computed read data and irq level, and a monitor
//  pops one entry for each read the DUT has sampled and compares out_bus and irq.
module tb_irq_controller;
  import irq_ctrl_pkg::*;

  localparam int NUM_SRC = 8;

  logic               clk    = 1'b0;
  logic               rst    = 1'b1;
  logic               read   = 1'b0;
  logic               write  = 1'b0;
  logic [1:0]         addr   = 2'd0;
  logic [15:0]        in_bus = 16'h0000;
  logic [15:0]        out_bus;
  logic [NUM_SRC-1:0] src    = '0;
  logic               irq;

  string       name_q[$];
  logic [15:0] data_q[$];
  logic        irq_q[$];

  int   n_compared     = 0;
  int   n_mismatched   = 0;
  logic rd_sampled     = 1'b0;
  logic drain_timeout  = 1'b0;
  logic timeout_logged = 1'b0;

`ifdef IRQ_EDGE_EN
  localparam logic [15:0] T6_SVC_PEND   = 16'h0000;
  localparam logic [15:0] T6_AFTER_PEND = 16'h0000;
  localparam logic        T6_AFTER_IRQ  = 1'b0;
`else
  localparam logic [15:0] T6_SVC_PEND   = 16'h0008;
  localparam logic [15:0] T6_AFTER_PEND = 16'h0008;
  localparam logic        T6_AFTER_IRQ  = 1'b1;
`endif

  irq_controller #(
    .NUM_SRC (NUM_SRC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .in_bus  (in_bus),
    .out_bus (out_bus),
    .src     (src),
    .irq     (irq)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Remembers that a read was sampled so the monitor knows out_bus is fresh.
  always @(posedge clk) begin
    rd_sampled <= read;
  end

  // Monitor: on the falling edge after a sampled read, pop the expected entry and compare.
  always @(negedge clk) begin
    string       nm;
    logic [15:0] ed;
    logic        ei;
    if (rd_sampled) begin
      if (data_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_read: out_bus=%h with no expected entry", out_bus);
      end else begin
        nm = name_q.pop_front();
        ed = data_q.pop_front();
        ei = irq_q.pop_front();
        n_compared++;
        if (out_bus !== ed) begin
          n_mismatched++;
          $display("[TB] FAIL %s_data: out_bus=%h expected %h", nm, out_bus, ed);
        end
        n_compared++;
        if (irq !== ei) begin
          n_mismatched++;
          $display("[TB] FAIL %s_irq: irq=%b expected %b", nm, irq, ei);
        end
      end
    end
    if (drain_timeout && !timeout_logged) begin
      timeout_logged = 1'b1;
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain_timeout: %0d entries left expected 0", data_q.size());
    end
  end

  // One bus cycle of stimulus, applied just after a rising edge and sampled on the next.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] a,
                               input logic [15:0] d, input logic [NUM_SRC-1:0] s);
    @(posedge clk);
    #1;
    read   = rd;
    write  = wr;
    addr   = a;
    in_bus = d;
    src    = s;
  endtask

  // Queues the expected read data and irq level, then issues the read.
  task automatic checkOutput(input string nm, input logic [1:0] a, input logic [15:0] ed,
                             input logic ei, input logic [NUM_SRC-1:0] s);
    name_q.push_back(nm);
    data_q.push_back(ed);
    irq_q.push_back(ei);
    applyStimulus(1'b1, 1'b0, a, 16'h0000, s);
  endtask

  task automatic idleStep(input logic [NUM_SRC-1:0] s);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, s);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [15:0] d, input logic [NUM_SRC-1:0] s);
    applyStimulus(1'b0, 1'b1, a, d, s);
  endtask

  // Directed test sequence.
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst_pending", ADDR_PENDING, 16'h0000, 1'b0, 8'h00);
    checkOutput("rst_mask",    ADDR_MASK,    16'h0000, 1'b0, 8'h00);
    checkOutput("rst_vector",  ADDR_VECTOR,  16'h0000, 1'b0, 8'h00);

    writeReg(ADDR_MASK, 16'h0001, 8'h00);
    checkOutput("t1_pre",  ADDR_PENDING, 16'h0000, 1'b0, 8'h01);
    checkOutput("t1_irq",  ADDR_PENDING, 16'h0001, 1'b1, 8'h00);
    checkOutput("t1_ack",  ADDR_VECTOR,  16'h8000, 1'b0, 8'h00);
    writeReg(ADDR_EOI, 16'h0000, 8'h00);
    checkOutput("t1_done", ADDR_PENDING, 16'h0000, 1'b0, 8'h00);

    writeReg(ADDR_MASK, 16'h00FF, 8'h00);
    idleStep(8'h24);
    idleStep(8'h00);
    checkOutput("t2_ack1",  ADDR_VECTOR,  16'h8002, 1'b0, 8'h00);
    writeReg(ADDR_EOI, 16'h0000, 8'h00);
    checkOutput("t2_reirq", ADDR_PENDING, 16'h0020, 1'b1, 8'h00);
    checkOutput("t2_ack2",  ADDR_VECTOR,  16'h8005, 1'b0, 8'h00);
    writeReg(ADDR_EOI, 16'h0000, 8'h00);

    idleStep(8'h01);
    idleStep(8'h00);
    checkOutput("t3_ack0",  ADDR_VECTOR,  16'h8000, 1'b0, 8'h00);
    idleStep(8'h02);
    checkOutput("t3_svc",   ADDR_PENDING, 16'h0002, 1'b0, 8'h00);
    writeReg(ADDR_EOI, 16'h0000, 8'h00);
    checkOutput("t3_reirq", ADDR_PENDING, 16'h0002, 1'b1, 8'h00);
    checkOutput("t3_ack1",  ADDR_VECTOR,  16'h8001, 1'b0, 8'h00);
    writeReg(ADDR_EOI, 16'h0000, 8'h00);
    checkOutput("t3_done",  ADDR_PENDING, 16'h0000, 1'b0, 8'h00);

    writeReg(ADDR_MASK, 16'h0000, 8'h00);
    idleStep(8'h10);
    checkOutput("t4_masked",  ADDR_PENDING, 16'h0010, 1'b0, 8'h00);
    writeReg(ADDR_PENDING, 16'h0010, 8'h10);
    checkOutput("t4_setwins", ADDR_PENDING, 16'h0010, 1'b0, 8'h00);
    writeReg(ADDR_PENDING, 16'h0010, 8'h00);
    checkOutput("t4_cleared", ADDR_PENDING, 16'h0000, 1'b0, 8'h00);

    writeReg(ADDR_MASK, 16'h00FF, 8'h00);
    idleStep(8'h08);
    idleStep(8'h00);
    checkOutput("t5_ack",  ADDR_VECTOR, 16'h8003, 1'b0, 8'h00);
    idleStep(8'h40);
    checkOutput("t5_spur", ADDR_VECTOR, 16'h0003, 1'b0, 8'h00);
    idleStep(8'h00);
    rst = 1'b1;
    idleStep(8'h00);
    rst = 1'b0;
    checkOutput("t5_rst_pend", ADDR_PENDING, 16'h0000, 1'b0, 8'h00);
    checkOutput("t5_rst_mask", ADDR_MASK,    16'h0000, 1'b0, 8'h00);
    checkOutput("t5_rst_vec",  ADDR_VECTOR,  16'h0000, 1'b0, 8'h00);

    writeReg(ADDR_MASK, 16'h0008, 8'h00);
    idleStep(8'h08);
    idleStep(8'h08);
    checkOutput("t6_ack",   ADDR_VECTOR,  16'h8003,      1'b0,         8'h08);
    checkOutput("t6_svc",   ADDR_PENDING, T6_SVC_PEND,   1'b0,         8'h08);
    idleStep(8'h00);
    writeReg(ADDR_EOI, 16'h0000, 8'h00);
    checkOutput("t6_after", ADDR_PENDING, T6_AFTER_PEND, T6_AFTER_IRQ, 8'h00);
    idleStep(8'h00);

    for (int i = 0; i < 10 && data_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (data_q.size() != 0) begin
      drain_timeout = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
